// File: rtl/shadow_cst_rev.sv
// shadow_cst_rev: reverse-order round-constant sequencer for the inverse
// Shadow-512 permutation. It fast-forwards the LFSR chain c_k = x^k*SEED
// mod (x^32 + x^8 + 1) up to c_{NCST-1}. It then streams c_{NCST-1} .. c_0
// out on a valid/ready interface, stepping backwards with the divide-by-x
// step.
module shadow_cst_rev #(
  parameter int unsigned NCST = 12,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [31:0] cst_out,
  output logic [7:0]  cst_idx,
  output logic        cst_valid,
  input  logic        cst_ready,
  output logic        cst_last
);

  localparam int unsigned CW = 32;
  localparam int unsigned IW = 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCST - 1);
  localparam logic [CW-1:0] TAP_MASK = 32'h0000_0101;
  localparam logic [CW-1:0] TAP_HI   = 32'h0000_0100;

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] val_q, val_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          busy_d, valid_d, last_d;

  // Multiply by x: a carry out of bit 31 folds back into taps x^8 and x^0.
  function automatic logic [CW-1:0] mul_x(input logic [CW-1:0] x);
    logic [CW-1:0] fb;
    fb = x[CW-1] ? TAP_MASK : '0;
    return {x[CW-2:0], 1'b0} ^ fb;
  endfunction

  // Divide by x: bit 0 reveals whether mul_x folded the taps, so undo that
  // fold and restore the bit that was shifted out of the top.
  function automatic logic [CW-1:0] div_x(input logic [CW-1:0] y);
    logic [CW-1:0] t;
    t = y ^ (y[0] ? TAP_HI : '0);
    return {y[0], t[CW-1:1]};
  endfunction

  // Next-state, datapath and output-flag decode.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = SEED;
          cnt_d   = '0;
          state_d = (NCST > 1) ? FWD : EMIT;
        end
      end
      FWD: begin
        val_d = mul_x(val_q);
        cnt_d = cnt_q + IW'(1);
        if (cnt_d == LAST_IDX) state_d = EMIT;
      end
      EMIT: begin
        if (cst_ready) begin
          if (cnt_q != '0) begin
            val_d = div_x(val_q);
            cnt_d = cnt_q - IW'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == EMIT);
    last_d  = valid_d && (cnt_d == '0);
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      val_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      cst_valid <= 1'b0;
      cst_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      cst_valid <= valid_d;
      cst_last  <= last_d;
    end
  end

  assign cst_out = val_q;
  assign cst_idx = cnt_q;

endmodule

// File: tb/tb_shadow_cst_rev.sv
// Directed bench for shadow_cst_rev. Four instances cover several
// (NCST, SEED) pairs and share clk, rst, start and cst_ready.
module tb_shadow_cst_rev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy_v  [4];
  logic [31:0] out_v   [4];
  logic [7:0]  idx_v   [4];
  logic        valid_v [4];
  logic        last_v  [4];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shadow_cst_rev #(.NCST(12), .SEED(32'h0000_0001)) u_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_v[0]), .cst_out(out_v[0]),
    .cst_idx(idx_v[0]), .cst_valid(valid_v[0]), .cst_ready(ready), .cst_last(last_v[0]));
  shadow_cst_rev #(.NCST(3), .SEED(32'h8000_0000)) u_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_v[1]), .cst_out(out_v[1]),
    .cst_idx(idx_v[1]), .cst_valid(valid_v[1]), .cst_ready(ready), .cst_last(last_v[1]));
  shadow_cst_rev #(.NCST(2), .SEED(32'hFFFF_FFFF)) u_c (
    .clk(clk), .rst(rst), .start(start), .busy(busy_v[2]), .cst_out(out_v[2]),
    .cst_idx(idx_v[2]), .cst_valid(valid_v[2]), .cst_ready(ready), .cst_last(last_v[2]));
  shadow_cst_rev #(.NCST(1), .SEED(32'h1234_5678)) u_d (
    .clk(clk), .rst(rst), .start(start), .busy(busy_v[3]), .cst_out(out_v[3]),
    .cst_idx(idx_v[3]), .cst_valid(valid_v[3]), .cst_ready(ready), .cst_last(last_v[3]));

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived constant c_k for each instance.
  function automatic logic [31:0] exp_val(input int id, input int k);
    case (id)
      0: return 32'h0000_0001 << k;
      1: case (k)
           0:       return 32'h8000_0000;
           1:       return 32'h0000_0101;
           default: return 32'h0000_0202;
         endcase
      2: return (k == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FEFF;
      default: return 32'h1234_5678;
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"},  32'(busy_v[i]),  32'd0);
      chk({tag, "_valid"}, 32'(valid_v[i]), 32'd0);
      chk({tag, "_last"},  32'(last_v[i]),  32'd0);
      chk({tag, "_out"},   out_v[i],        32'd0);
      chk({tag, "_idx"},   32'(idx_v[i]),   32'd0);
    end
  endtask

  task automatic wait_idle();
    int g;
    int nb;
    g = 0;
    nb = 4;
    while (nb != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
      nb = 0;
      for (int i = 0; i < 4; i++) nb += int'(busy_v[i]);
    end
    chk("all_idle", 32'(nb), 32'd0);
  endtask

  // mode 0: plain run; 1: stray start pulses in FWD and EMIT;
  // 2: start held on the final-handshake cycle.
  task automatic run_seq(input int id, input int n, input bit bp, input int mode);
    int  cyc;
    int  k;
    int  guard;
    logic rdy;
    @(posedge clk); #1;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    chk("busy_rise", 32'(busy_v[id]), 32'd1);
    while (!valid_v[id] && cyc < 600) begin
      chk("fwd_busy", 32'(busy_v[id]), 32'd1);
      start = (mode == 1 && cyc == 2);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("fwd_len", 32'(cyc), 32'(n - 1));
    k = n - 1;
    guard = 0;
    while (k >= 0 && guard < 2000) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      chk("valid", 32'(valid_v[id]), 32'd1);
      chk("out",   out_v[id],        exp_val(id, k));
      chk("idx",   32'(idx_v[id]),   32'(k));
      chk("last",  32'(last_v[id]),  32'(k == 0));
      start = (mode == 1 && k == n / 2) || (mode == 2 && k == 0 && rdy);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      guard++;
      if (rdy) k--;
    end
    ready = 1'b1;
    chk("emit_cnt", 32'(k + 1), 32'd0);
    if (!bp) chk("busy_fall", 32'(cyc), 32'(2 * n - 1));
    chk("busy_end",  32'(busy_v[id]),  32'd0);
    chk("valid_end", 32'(valid_v[id]), 32'd0);
    chk("last_end",  32'(last_v[id]),  32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_restart", 32'(busy_v[id]), 32'd0);
    end
    wait_idle();
  endtask

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_zero("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_rel");

    run_seq(0, 12, 1'b0, 0);
    run_seq(1, 3, 1'b0, 0);
    run_seq(2, 2, 1'b0, 0);
    run_seq(3, 1, 1'b0, 0);

    run_seq(0, 12, 1'b1, 0);
    run_seq(1, 3, 1'b1, 0);
    run_seq(2, 2, 1'b1, 0);

    run_seq(0, 12, 1'b0, 1);
    run_seq(1, 3, 1'b0, 1);
    run_seq(0, 12, 1'b0, 2);
    run_seq(2, 2, 1'b0, 2);

    // Reset in the middle of FWD, then a clean restart.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_fwd_busy", 32'(busy_v[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_fwd");
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(0, 12, 1'b0, 0);

    // Reset in the middle of EMIT, then a clean restart.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_emit_valid", 32'(valid_v[0]), 32'd1);
    chk("pre_rst_emit_idx",   32'(idx_v[0]),   32'd8);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_emit");
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(0, 12, 1'b0, 0);
    run_seq(1, 3, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/shadow_cst_rev.md
# shadow_cst_rev

Reverse-order round-constant sequencer for the inverse Shadow-512 permutation. It regenerates the 32-bit LFSR constant chain c_k = x^k·SEED mod P(x), with P(x) = x^32 + x^8 + 1. It does this by first fast-forwarding from SEED with the multiply-by-x step, then emitting c_{NCST-1} … c_0 through a valid/ready stream using the divide-by-x step. It feeds the constant-addition stage of the inverse permutation datapath, which consumes constants last-to-first.

## Interface
- NCST, 12, number of constants per sequence; legal range 1..256
- SEED, 32'h00000001, value of c_0
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sequence request; sampled only in IDLE
- busy  out  1  high in FWD and EMIT
- cst_out  out  32  current constant
- cst_idx  out  8  index k of cst_out; counts down
- cst_valid  out  1  cst_out is valid (EMIT only)
- cst_ready  in  1  consumer accepts cst_out
- cst_last  out  1  high with cst_valid when cst_idx == 0

## Operation
- Forward step: mul(x) = (x<<1) ^ b ^ (b<<8), with b = x[31] replicated as a 0/1 word.
- Inverse step: div(y) = ((y ^ (y[0]<<8)) >> 1) | (y[0]<<31). It is the exact inverse of mul for all 2^32 inputs.
- Both steps are combinational functions inside the block. All arithmetic is 32 bits with no carries; XOR only.
- State register reg[31:0], counter cnt[7:0], FSM {IDLE, FWD, EMIT}.
- IDLE:
  - start=1 loads reg<=SEED and cnt<=0.
  - Next state is FWD if NCST>1, else EMIT.
- FWD:
  - Each cycle, reg<=mul(reg) and cnt<=cnt+1.
  - When cnt reaches NCST-1, go to EMIT.
  - Neither start nor cst_ready affects FWD.
- EMIT:
  - cst_valid=1, cst_out=reg, cst_idx=cnt.
  - On cst_valid&cst_ready with cnt!=0: reg<=div(reg), cnt<=cnt-1.
  - On cst_valid&cst_ready with cnt==0: go to IDLE. reg and cnt are left unchanged.
  - Without ready, cst_out, cst_idx and cst_last hold stable.
- start while busy is ignored and not queued. A start coinciding with the final handshake is also ignored, because start is sampled only in IDLE.
- The final emitted constant equals SEED. This is an invariant the datapath relies on.
- Reset (async, at any time, including mid-FWD or mid-EMIT):
  - FSM=IDLE, reg=0, cnt=0.
  - Outputs: busy=0, cst_valid=0, cst_last=0, cst_out=0, cst_idx=0.
  - There is no partial-sequence recovery; the consumer must restart.
- Outputs are driven from registers and FSM state only. There is no combinational path from cst_ready or start to any output.

## Timing
- Let edge t be the edge at which start is captured in IDLE.
- busy rises after edge t.
- For NCST>1:
  - FWD occupies edges t+1 .. t+NCST-1.
  - cst_valid rises after edge t+NCST-1 with cst_idx=NCST-1.
- For NCST=1, cst_valid rises after edge t.
- Throughput is one constant per cycle while cst_ready=1.
- With ready held high, the final handshake occurs at edge t+2·NCST-1. busy and cst_valid fall after it.
- The earliest new start is captured at the edge following the return to IDLE.

## Test plan
- SEED=1, NCST=12, ready=1, start pulse:
  - FWD lasts 11 cycles.
  - Output sequence is 0x800, 0x400, …, 0x2, 0x1, with cst_idx 11..0.
  - cst_last is high only on 0x1.
  - busy falls at edge t+23.
- Polynomial wrap, SEED=0x80000000, NCST=3: emits 0x00000202, 0x00000101, 0x80000000.
- All-ones, SEED=0xFFFFFFFF, NCST=2: emits 0xFFFFFEFF, then 0xFFFFFFFF.
- Backpressure: drive ready with a random pattern (50% low).
  - Values and indices match the ready=1 run.
  - cst_out, cst_idx and cst_last are stable during every valid&!ready cycle.
- Boundary cases:
  - NCST=1: emits SEED one cycle after start, with cst_last=1.
  - start pulses during FWD and EMIT are ignored, and the sequence is unchanged.
  - start asserted on the final-handshake cycle produces no new sequence.
- Reset mid-FWD and mid-EMIT:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After reset release, a new start produces the full correct sequence.
  - Exhaustive random check: div(mul(v)) == v for 10^6 random v.
